// File: rtl/rv32i_decode_stage.sv
// RV32I instruction decode stage: combinational decoder feeding a single
// valid/ready output register toward execute.
package rv32i_pkg;

    localparam int unsigned XLEN_W = 32;

    typedef enum logic [1:0] {A_REG = 2'd0, A_PC = 2'd1, A_ZERO = 2'd2} ASel_e;
    typedef enum logic       {B_REG = 1'b0, B_IMM = 1'b1} BSel_e;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
        ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
        ALU_OR   = 4'd8, ALU_AND = 4'd9
    } ALUSel_e;
    typedef enum logic [1:0] {WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC = 2'd2} WBSel_e;
    typedef enum logic [2:0] {IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3, IMM_U = 3'd4} ImmSel_e;

    typedef struct packed {
        logic [XLEN_W-1:0] pc;
        logic [XLEN_W-1:0] imm;
        logic [4:0]        rs1_idx;
        logic [4:0]        rs2_idx;
        logic [4:0]        rd_idx;
        logic [2:0]        funct3;
        ASel_e             asel;
        BSel_e             bsel;
        ALUSel_e           alusel;
        WBSel_e            wbsel;
        logic              reg_wen;
        logic              mem_ren;
        logic              mem_wen;
        logic              branch;
        logic              jump;
        logic              illegal;
    } dec_t;

endpackage

module rv32i_decode_stage
    import rv32i_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic            id_ready,
    input  logic            flush,
    input  logic            ex_ready,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1_idx,
    output logic [4:0]      ex_rs2_idx,
    output logic [4:0]      ex_rd_idx,
    output logic [2:0]      ex_funct3,
    output ASel_e           ex_asel,
    output BSel_e           ex_bsel,
    output ALUSel_e         ex_alusel,
    output WBSel_e          ex_wbsel,
    output logic            ex_reg_wen,
    output logic            ex_mem_ren,
    output logic            ex_mem_wen,
    output logic            ex_branch,
    output logic            ex_jump,
    output logic            ex_illegal
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       is_op;
    logic       load;
    ImmSel_e    imm_sel;
    dec_t       dec_c;
    dec_t       dec_q, dec_d;
    logic       valid_q, valid_d;

    assign opcode = if_instr[6:0];
    assign f3     = if_instr[14:12];
    assign f7     = if_instr[31:25];
    assign is_op  = (opcode == OPC_OP);

    // Instruction decoder
    always_comb begin
        imm_sel       = IMM_I;
        dec_c         = '0;
        dec_c.pc      = if_pc;
        dec_c.rs1_idx = if_instr[19:15];
        dec_c.rs2_idx = if_instr[24:20];
        dec_c.rd_idx  = if_instr[11:7];
        dec_c.funct3  = f3;
        dec_c.asel    = A_REG;
        dec_c.bsel    = B_IMM;
        dec_c.alusel  = ALU_ADD;
        dec_c.wbsel   = WB_ALU;

        unique case (opcode)
            OPC_LUI: begin
                imm_sel       = IMM_U;
                dec_c.asel    = A_ZERO;
                dec_c.reg_wen = 1'b1;
            end
            OPC_AUIPC: begin
                imm_sel       = IMM_U;
                dec_c.asel    = A_PC;
                dec_c.reg_wen = 1'b1;
            end
            OPC_JAL: begin
                imm_sel       = IMM_J;
                dec_c.asel    = A_PC;
                dec_c.wbsel   = WB_PC;
                dec_c.reg_wen = 1'b1;
                dec_c.jump    = 1'b1;
            end
            OPC_JALR: begin
                dec_c.wbsel   = WB_PC;
                dec_c.reg_wen = 1'b1;
                dec_c.jump    = 1'b1;
                dec_c.illegal = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                imm_sel       = IMM_B;
                dec_c.asel    = A_PC;
                dec_c.branch  = 1'b1;
                dec_c.illegal = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OPC_LOAD: begin
                dec_c.wbsel   = WB_MEM;
                dec_c.mem_ren = 1'b1;
                dec_c.reg_wen = 1'b1;
                dec_c.illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OPC_STORE: begin
                imm_sel       = IMM_S;
                dec_c.mem_wen = 1'b1;
                dec_c.illegal = (f3 > 3'b010);
            end
            OPC_OPIMM, OPC_OP: begin
                dec_c.bsel    = is_op ? B_REG : B_IMM;
                dec_c.reg_wen = 1'b1;
                unique case (f3)
                    3'b000: begin
                        dec_c.alusel  = (is_op && f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
                        dec_c.illegal = is_op && (f7 != F7_ZERO) && (f7 != F7_ALT);
                    end
                    3'b001: begin
                        dec_c.alusel  = ALU_SLL;
                        dec_c.illegal = (f7 != F7_ZERO);
                    end
                    3'b101: begin
                        dec_c.alusel  = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        dec_c.illegal = (f7 != F7_ZERO) && (f7 != F7_ALT);
                    end
                    default: begin
                        unique case (f3)
                            3'b010:  dec_c.alusel = ALU_SLT;
                            3'b011:  dec_c.alusel = ALU_SLTU;
                            3'b100:  dec_c.alusel = ALU_XOR;
                            3'b110:  dec_c.alusel = ALU_OR;
                            default: dec_c.alusel = ALU_AND;
                        endcase
                        // OP-IMM reuses bits 31:25 as immediate here, so only OP checks them
                        dec_c.illegal = is_op && (f7 != F7_ZERO);
                    end
                endcase
            end
            OPC_FENCE: ;
            default: dec_c.illegal = 1'b1;
        endcase

        if (dec_c.illegal) begin
            dec_c.reg_wen = 1'b0;
            dec_c.mem_ren = 1'b0;
            dec_c.mem_wen = 1'b0;
            dec_c.branch  = 1'b0;
            dec_c.jump    = 1'b0;
        end
        if (dec_c.rd_idx == 5'd0) begin
            dec_c.reg_wen = 1'b0;
        end

        unique case (imm_sel)
            IMM_S:   dec_c.imm = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
            IMM_B:   dec_c.imm = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                                  if_instr[30:25], if_instr[11:8], 1'b0};
            IMM_J:   dec_c.imm = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                                  if_instr[20], if_instr[30:21], 1'b0};
            IMM_U:   dec_c.imm = {if_instr[31:12], 12'b0};
            default: dec_c.imm = {{20{if_instr[31]}}, if_instr[31:20]};
        endcase
    end

    assign id_ready = flush | ~valid_q | ex_ready;
    assign load     = if_valid & id_ready & ~flush;

    // Output register next state; flush beats load beats drain
    always_comb begin
        valid_d = valid_q;
        dec_d   = dec_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            dec_d   = dec_c;
        end else if (ex_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            dec_q   <= '0;
        end else begin
            valid_q <= valid_d;
            dec_q   <= dec_d;
        end
    end

    assign ex_valid   = valid_q;
    assign ex_pc      = dec_q.pc;
    assign ex_imm     = dec_q.imm;
    assign ex_rs1_idx = dec_q.rs1_idx;
    assign ex_rs2_idx = dec_q.rs2_idx;
    assign ex_rd_idx  = dec_q.rd_idx;
    assign ex_funct3  = dec_q.funct3;
    assign ex_asel    = dec_q.asel;
    assign ex_bsel    = dec_q.bsel;
    assign ex_alusel  = dec_q.alusel;
    assign ex_wbsel   = dec_q.wbsel;
    assign ex_reg_wen = dec_q.reg_wen;
    assign ex_mem_ren = dec_q.mem_ren;
    assign ex_mem_wen = dec_q.mem_wen;
    assign ex_branch  = dec_q.branch;
    assign ex_jump    = dec_q.jump;
    assign ex_illegal = dec_q.illegal;

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Directed bench for rv32i_decode_stage with a reference decoder and a
// scoreboard of expected held entries.
module tb_rv32i_decode_stage;
    import rv32i_pkg::*;

    typedef struct packed {
        dec_t v;
        logic care_sel;
        logic care_wb;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        flush;
    logic        ex_ready;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rs1_idx, ex_rs2_idx, ex_rd_idx;
    logic [2:0]  ex_funct3;
    ASel_e       ex_asel;
    BSel_e       ex_bsel;
    ALUSel_e     ex_alusel;
    WBSel_e      ex_wbsel;
    logic        ex_reg_wen, ex_mem_ren, ex_mem_wen, ex_branch, ex_jump, ex_illegal;

    int   checks = 0;
    int   errors = 0;
    sb_t  exp_q[$];
    logic mv = 1'b0;
    dec_t snap;

    rv32i_decode_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_ready(id_ready), .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1_idx(ex_rs1_idx), .ex_rs2_idx(ex_rs2_idx),
        .ex_rd_idx(ex_rd_idx), .ex_funct3(ex_funct3), .ex_asel(ex_asel), .ex_bsel(ex_bsel),
        .ex_alusel(ex_alusel), .ex_wbsel(ex_wbsel), .ex_reg_wen(ex_reg_wen),
        .ex_mem_ren(ex_mem_ren), .ex_mem_wen(ex_mem_wen), .ex_branch(ex_branch),
        .ex_jump(ex_jump), .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic dec_t obs_dec();
        dec_t o;
        o.pc = ex_pc; o.imm = ex_imm;
        o.rs1_idx = ex_rs1_idx; o.rs2_idx = ex_rs2_idx; o.rd_idx = ex_rd_idx;
        o.funct3 = ex_funct3; o.asel = ex_asel; o.bsel = ex_bsel;
        o.alusel = ex_alusel; o.wbsel = ex_wbsel;
        o.reg_wen = ex_reg_wen; o.mem_ren = ex_mem_ren; o.mem_wen = ex_mem_wen;
        o.branch = ex_branch; o.jump = ex_jump; o.illegal = ex_illegal;
        return o;
    endfunction

    // Reference decoder: every opcode sets its full field list explicitly
    function automatic sb_t ref_dec(logic [31:0] w, logic [31:0] pc);
        sb_t        e;
        logic [6:0] op = w[6:0];
        logic [2:0] f3 = w[14:12];
        logic [6:0] f7 = w[31:25];
        logic [31:0] imm_i = {{20{w[31]}}, w[31:20]};
        logic [31:0] imm_s = {{20{w[31]}}, w[31:25], w[11:7]};
        logic [31:0] imm_b = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
        logic [31:0] imm_j = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        logic [31:0] imm_u = {w[31:12], 12'h000};
        logic        ok;
        e = '0;
        e.care_sel = 1'b1; e.care_wb = 1'b1;
        e.v.pc = pc; e.v.rs1_idx = w[19:15]; e.v.rs2_idx = w[24:20];
        e.v.rd_idx = w[11:7]; e.v.funct3 = f3;
        e.v.alusel = ALU_ADD; e.v.bsel = B_IMM; e.v.wbsel = WB_ALU;
        ok = 1'b1;
        case (op)
            7'h37: begin e.v.imm = imm_u; e.v.asel = A_ZERO; e.v.reg_wen = 1'b1; end
            7'h17: begin e.v.imm = imm_u; e.v.asel = A_PC; e.v.reg_wen = 1'b1; end
            7'h6F: begin e.v.imm = imm_j; e.v.asel = A_PC; e.v.wbsel = WB_PC;
                         e.v.reg_wen = 1'b1; e.v.jump = 1'b1; end
            7'h67: begin ok = (f3 == 3'd0); e.v.imm = imm_i; e.v.asel = A_REG;
                         e.v.wbsel = WB_PC; e.v.reg_wen = 1'b1; e.v.jump = 1'b1; end
            7'h63: begin ok = !(f3 == 3'd2 || f3 == 3'd3); e.v.imm = imm_b; e.v.asel = A_PC;
                         e.v.branch = 1'b1; e.care_wb = 1'b0; end
            7'h03: begin ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}); e.v.imm = imm_i;
                         e.v.asel = A_REG; e.v.wbsel = WB_MEM; e.v.mem_ren = 1'b1;
                         e.v.reg_wen = 1'b1; end
            7'h23: begin ok = (f3 inside {3'd0, 3'd1, 3'd2}); e.v.imm = imm_s; e.v.asel = A_REG;
                         e.v.mem_wen = 1'b1; e.care_wb = 1'b0; end
            7'h13, 7'h33: begin
                e.v.imm = imm_i; e.v.asel = A_REG; e.v.reg_wen = 1'b1;
                e.v.bsel = (op == 7'h33) ? B_REG : B_IMM;
                if (op == 7'h33) begin
                    e.care_sel = 1'b1;
                    ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                end else if (f3 == 3'd1) ok = (f7 == 7'h00);
                else if (f3 == 3'd5) ok = (f7 == 7'h00 || f7 == 7'h20);
                case (f3)
                    3'd0: e.v.alusel = (op == 7'h33 && f7 == 7'h20) ? ALU_SUB : ALU_ADD;
                    3'd1: e.v.alusel = ALU_SLL;
                    3'd2: e.v.alusel = ALU_SLT;
                    3'd3: e.v.alusel = ALU_SLTU;
                    3'd4: e.v.alusel = ALU_XOR;
                    3'd5: e.v.alusel = (f7 == 7'h20) ? ALU_SRA : ALU_SRL;
                    3'd6: e.v.alusel = ALU_OR;
                    default: e.v.alusel = ALU_AND;
                endcase
            end
            7'h0F: begin e.care_sel = 1'b0; e.care_wb = 1'b0; end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            e.v.illegal = 1'b1; e.v.reg_wen = 1'b0; e.v.mem_ren = 1'b0;
            e.v.mem_wen = 1'b0; e.v.branch = 1'b0; e.v.jump = 1'b0;
            e.care_sel = 1'b0; e.care_wb = 1'b0;
        end
        if (e.v.rd_idx == 5'd0) e.v.reg_wen = 1'b0;
        return e;
    endfunction

    task automatic check_out(input string tag);
        sb_t  e;
        dec_t o, x;
        chk({tag, "_valid"}, 128'(ex_valid), 128'(mv));
        if (mv) begin
            e = exp_q[0];
            o = obs_dec();
            x = e.v;
            if (!e.care_sel) begin
                o.imm = '0; x.imm = '0; o.asel = A_REG; x.asel = A_REG;
                o.bsel = B_REG; x.bsel = B_REG; o.alusel = ALU_ADD; x.alusel = ALU_ADD;
            end
            if (!e.care_wb) begin
                o.wbsel = WB_ALU; x.wbsel = WB_ALU;
            end
            chk({tag, "_entry"}, 128'(o), 128'(x));
        end
    endtask

    // One cycle: drive at negedge, check ready, advance model, check outputs next negedge
    task automatic drive(input string tag, input logic iv, input logic [31:0] ins,
                         input logic [31:0] pc, input logic fl, input logic er);
        logic rdy;
        if_valid = iv; if_instr = ins; if_pc = pc; flush = fl; ex_ready = er;
        #1;
        rdy = fl | ~mv | er;
        chk({tag, "_id_ready"}, 128'(id_ready), 128'(rdy));
        if (fl) begin
            exp_q.delete();
            mv = 1'b0;
        end else if (iv && rdy) begin
            if (mv) void'(exp_q.pop_front());
            exp_q.push_back(ref_dec(ins, pc));
            mv = 1'b1;
        end else if (er && mv) begin
            void'(exp_q.pop_front());
            mv = 1'b0;
        end
        @(negedge clk);
        check_out(tag);
    endtask

    initial begin
        rst_n = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0; flush = 1'b0; ex_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 128'(ex_valid), 128'(0));
        chk("rst_fields", 128'(obs_dec()), 128'(0));
        rst_n = 1'b1;

        drive("addi", 1'b1, 32'hFFF10093, 32'h0000_0100, 1'b0, 1'b1);
        chk("addi_imm", 128'(ex_imm), 128'(32'hFFFF_FFFF));
        chk("addi_idx", 128'({ex_rd_idx, ex_rs1_idx}), 128'({5'd1, 5'd2}));
        chk("addi_sel", 128'({ex_alusel, ex_bsel, ex_reg_wen}), 128'({ALU_ADD, B_IMM, 1'b1}));

        drive("sub", 1'b1, 32'h402081B3, 32'h0000_0104, 1'b0, 1'b1);
        chk("sub_sel", 128'({ex_alusel, ex_bsel, ex_asel, ex_rd_idx, ex_reg_wen}),
            128'({ALU_SUB, B_REG, A_REG, 5'd3, 1'b1}));

        drive("lui", 1'b1, 32'h123452B7, 32'h0000_0108, 1'b0, 1'b1);
        chk("lui_imm", 128'({ex_imm, ex_asel}), 128'({32'h1234_5000, A_ZERO}));

        drive("beq", 1'b1, 32'hFE000EE3, 32'h0000_010C, 1'b0, 1'b1);
        chk("beq_fields", 128'({ex_imm, ex_asel, ex_branch, ex_reg_wen}),
            128'({32'hFFFF_FFFC, A_PC, 1'b1, 1'b0}));

        drive("auipc", 1'b1, 32'h00001217, 32'h0000_0110, 1'b0, 1'b1);
        drive("jal",   1'b1, 32'h008000EF, 32'h0000_0114, 1'b0, 1'b1);
        drive("jalr",  1'b1, 32'h000100E7, 32'h0000_0118, 1'b0, 1'b1);
        drive("lw",    1'b1, 32'h00412303, 32'h0000_011C, 1'b0, 1'b1);
        drive("sw",    1'b1, 32'h00612423, 32'h0000_0120, 1'b0, 1'b1);
        drive("xor",   1'b1, 32'h0020C3B3, 32'h0000_0124, 1'b0, 1'b1);
        drive("srai",  1'b1, 32'h4030D413, 32'h0000_0128, 1'b0, 1'b1);
        drive("slli_bad", 1'b1, 32'h40309413, 32'h0000_012C, 1'b0, 1'b1);
        drive("fence", 1'b1, 32'h0FF0000F, 32'h0000_0130, 1'b0, 1'b1);
        drive("jalr_bad", 1'b1, 32'h000110E7, 32'h0000_0134, 1'b0, 1'b1);
        drive("br_bad", 1'b1, 32'h00002063, 32'h0000_0138, 1'b0, 1'b1);
        drive("ld_bad", 1'b1, 32'h0000B303, 32'h0000_013C, 1'b0, 1'b1);
        drive("add_x0", 1'b1, 32'h00208033, 32'h0000_0140, 1'b0, 1'b1);
        chk("add_x0_wen", 128'(ex_reg_wen), 128'(0));
        drive("sltiu", 1'b1, 32'h0050B493, 32'h0000_0144, 1'b0, 1'b1);
        drive("and",   1'b1, 32'h0020F533, 32'h0000_0148, 1'b0, 1'b1);

        // Stall three cycles with a new offer pending, then release
        snap = obs_dec();
        for (int i = 0; i < 3; i++) drive("stall", 1'b1, 32'h00310193, 32'h0000_0200, 1'b0, 1'b0);
        chk("stall_hold", 128'(obs_dec()), 128'(snap));
        drive("release", 1'b1, 32'h00310193, 32'h0000_0200, 1'b0, 1'b1);
        chk("release_pc", 128'(ex_pc), 128'(32'h0000_0200));

        drive("flush", 1'b1, 32'h00500293, 32'h0000_0300, 1'b1, 1'b0);
        drive("illegal0", 1'b1, 32'h00000000, 32'h0000_0304, 1'b0, 1'b1);
        chk("illegal0_flags", 128'({ex_illegal, ex_reg_wen, ex_mem_ren, ex_mem_wen, ex_branch, ex_jump}),
            128'(6'b100000));

        // Asynchronous reset in the middle of a stall
        drive("prestall", 1'b1, 32'h00700393, 32'h0000_0400, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 128'(ex_valid), 128'(0));
        chk("async_rst_fields", 128'(obs_dec()), 128'(0));
        exp_q.delete();
        mv = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive("post_rst", 1'b1, 32'hFFF10093, 32'h0000_0500, 1'b0, 1'b0);
        drive("drain", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
